dcache_dirty_flush: RTL
=======================

Name: dcache_dirty_flush

Overview:
- Flush/writeback sequencer for the data-cache dirty-bit array; consumer side of the dirty tracker.
- On a start pulse it walks every line index and reads each dirty bit through the tracker's registered read port.
- For each dirty line it issues a writeback request over a valid/ready handshake, then clears that line's dirty bit via a tracker write port.
- Stores landing on already-scanned lines during a flush trigger a bounded rescan.

Parameters:
- ADDR_WIDTH, 6, line-index width.
- ENTRIES, 64, lines scanned per pass; max index ENTRIES-1.
- MAX_PASSES, 2, maximum scan passes per flush, including rescans; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  flush request pulse; ignored unless idle
- busy  out  1  flush in progress
- done  out  1  one-cycle pulse at flush end
- done_clean  out  1  valid with done; 1 = no unserviced rescan request remained
- rd_addr  out  ADDR_WIDTH  dirty-array read index
- rd_clkEn  out  1  read enable; index is registered by the tracker, data returns the next cycle
- rd_dirty  in  1  dirty bit for the index registered on the previous rd_clkEn
- clr_addr  out  ADDR_WIDTH  index whose dirty bit is cleared
- clr_wen  out  1  clear strobe
- set_addr  in  ADDR_WIDTH  store-side dirty-set index (snooped)
- set_wen  in  1  store-side dirty-set strobe
- wb_valid  out  1  writeback request valid
- wb_addr  out  ADDR_WIDTH  line index being written back
- wb_ready  in  1  writeback acceptor ready

Behaviour:
- Reset, sync, all state: FSM=IDLE, ptr=0, pass=0, rescan=0. All outputs are 0 in the cycle after rst is sampled high.
- rst mid-flush abandons the flush without a done pulse. A wb_valid that is high is dropped without acceptance.
- States: IDLE, READ, CHECK, REQ, DONE.
- IDLE: if start=1, go to READ with ptr=0, pass=0, rescan=0.
- READ: rd_clkEn=1, rd_addr=ptr. Go to CHECK.
- CHECK: sample rd_dirty.
  - rd_dirty=1: go to REQ.
  - rd_dirty=0: advance.
- REQ: wb_valid=1, wb_addr=ptr, held stable until accepted.
  - Acceptance is the cycle with wb_valid&wb_ready.
  - In the acceptance cycle: clr_wen=1, clr_addr=ptr, then advance.
  - wb_valid never deasserts before acceptance.
- Clear/set collision: if set_wen=1 and set_addr==ptr in the acceptance cycle, clr_wen is forced to 0 and the line stays dirty.
- Advance:
  - If ptr<ENTRIES-1: ptr+1, go to READ.
  - If ptr==ENTRIES-1 and rescan=1 and pass<MAX_PASSES-1: pass+1, ptr=0, rescan=0, go to READ.
  - Otherwise go to DONE.
- Rescan tracking: while busy, set_wen=1 with set_addr<=ptr (unsigned) sets rescan=1. set_addr>ptr is ignored because that line is still ahead of the scan.
- Collision case: set_addr==ptr in REQ counts as <=ptr, so it also sets rescan.
- DONE: done=1 and done_clean=~rescan for exactly one cycle, then IDLE.
- busy=1 in READ, CHECK, REQ, DONE; 0 in IDLE.
- Timing: a clean line costs 2 cycles. A dirty line costs 2 + (wait cycles) + 1 cycles.
- Flush latency with all lines clean and wb unused: 2*ENTRIES+1 cycles from start to done.
- start while busy: ignored; no effect on the current flush.
- ptr wraps only through the end-of-pass rule; there is no modular overflow.

Test Plan:
- All clean, ENTRIES=64, start pulse -> 128 READ/CHECK cycles, no wb_valid, done at cycle 129, done_clean=1.
- Lines 3 and 40 dirty, wb_ready tied 1 -> exactly two requests, wb_addr=3 then 40; clr_wen with clr_addr=3 and 40 in the acceptance cycles; done_clean=1.
- Line 5 dirty, wb_ready held 0 for 4 cycles -> wb_valid and wb_addr=5 stable for 5 cycles; single clr_wen on the accept cycle.
- Store set_addr=2 while ptr=10 -> second pass starts at ptr=0. Store set_addr=20 while ptr=10 -> no rescan. With MAX_PASSES=2 and another store to a scanned line in pass 2 -> done with done_clean=0.
- Line 7 accept cycle coincides with set_wen, set_addr=7 -> clr_wen=0 that cycle; rescan set; line 7 is written back again in pass 2.
- rst asserted while in REQ at ptr=30 -> next cycle busy=0, wb_valid=0, no done. A new start rescans from ptr=0. A start pulse mid-flush is ignored (ptr unchanged).

Source files
------------

// File: rtl/dcache_dirty_flush.sv
// -----------------------------------------------------------------------------
// dcache_dirty_flush
//
// Flush/writeback sequencer for the data-cache dirty-bit array. It sits on the
// consumer side of the dirty tracker. A start pulse walks every line index and
// reads each dirty bit through the tracker's registered read port. Each dirty
// line gets a writeback request, and the line's dirty bit is cleared once that
// request is accepted. Stores that land on already-scanned lines during a flush
// trigger another pass. The number of passes is bounded by MAX_PASSES.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                flush request pulse (ignored unless idle)
//   busy                 flush in progress
//   done, done_clean     one-cycle end-of-flush pulse; done_clean=1 when no
//                        unserviced rescan request remained
//   rd_addr, rd_clkEn    dirty-array read request (data returns next cycle)
//   rd_dirty             dirty bit for the previously requested index
//   clr_addr, clr_wen    dirty-bit clear port
//   set_addr, set_wen    snooped store-side dirty-set port
//   wb_valid, wb_addr    writeback request
//   wb_ready             writeback acceptor ready
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// READ   | read request for line ptr issued to the tracker
// CHECK  | tracker data for line ptr is valid; branch on dirty bit
// REQ    | writeback request for line ptr held until accepted
// DONE   | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module dcache_dirty_flush #(
  parameter int ADDR_WIDTH = 6,
  parameter int ENTRIES    = 64,
  parameter int MAX_PASSES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  done_clean,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_clkEn,
  input  logic                  rd_dirty,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_wen,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  set_wen,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  wb_ready
);

  localparam int PASS_W = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(ENTRIES - 1);
  localparam logic [PASS_W-1:0]     PASS_LAST = PASS_W'(MAX_PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_REQ   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [PASS_W-1:0]       pass_q, pass_d;
  logic                    rescan_q, rescan_d;

  logic                    in_flush;
  logic                    accept;
  logic                    set_hits_scanned;
  logic                    rescan_now;
  logic                    at_last;
  logic                    advance;

  assign in_flush = (state_q != S_IDLE);
  assign accept   = (state_q == S_REQ) && wb_ready;
  assign at_last  = (ptr_q == PTR_LAST);

  // A store at or behind the scan pointer dirties a line this pass has already
  // covered (or is covering right now), so another pass is needed to catch it.
  assign set_hits_scanned = in_flush && set_wen && (set_addr <= ptr_q);

  // Include a same-cycle store so a hit on the final line's advance still
  // earns a rescan instead of only marking the flush unclean.
  assign rescan_now = rescan_q || set_hits_scanned;

  assign advance = ((state_q == S_CHECK) && !rd_dirty) || accept;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      pass_q   <= '0;
      rescan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pass_q   <= pass_d;
      rescan_q <= rescan_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    pass_d   = pass_q;
    rescan_d = rescan_q;

    if (set_hits_scanned) begin
      rescan_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_READ;
          ptr_d    = '0;
          pass_d   = '0;
          rescan_d = 1'b0;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (rd_dirty) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Held here until accepted; the advance below handles the exit.
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leaving a line: step forward, start another pass, or finish.
    if (advance) begin
      if (!at_last) begin
        ptr_d   = ptr_q + ADDR_WIDTH'(1);
        state_d = S_READ;
      end else if (rescan_now && (pass_q < PASS_LAST)) begin
        // The new pass revisits every line, so any pending request is covered.
        pass_d   = pass_q + PASS_W'(1);
        ptr_d    = '0;
        rescan_d = 1'b0;
        state_d  = S_READ;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = in_flush;
    done       = 1'b0;
    done_clean = 1'b0;
    rd_clkEn   = 1'b0;
    rd_addr    = '0;
    clr_wen    = 1'b0;
    clr_addr   = '0;
    wb_valid   = 1'b0;
    wb_addr    = '0;

    unique case (state_q)
      S_READ: begin
        rd_clkEn = 1'b1;
        rd_addr  = ptr_q;
      end
      S_REQ: begin
        wb_valid = 1'b1;
        wb_addr  = ptr_q;
        // A store to this same line in the accept cycle must win over the
        // clear, otherwise the new data would lose its dirty mark.
        if (wb_ready && !(set_wen && (set_addr == ptr_q))) begin
          clr_wen  = 1'b1;
          clr_addr = ptr_q;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        done_clean = ~rescan_q;
      end
      default: begin
      end
    endcase
  end

endmodule
